gshare_spec_predictor: RTL and testbench
========================================

GSHARE_SPEC_PREDICTOR -- requirements
Module: gshare_spec_predictor

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32: width of predict/update PC.
REQ-002 SHALL have parameter INDEX_BITS, default 12: log2 of counter-table depth.
REQ-003 SHALL have parameter HIST_BITS, default 12: global history length; legal range 1..INDEX_BITS.
REQ-004 SHALL have parameter PC_LSB, default 2: count of low PC bits dropped before indexing.
REQ-005 SHALL have parameter INIT_STATE, default 2'b10: per-entry counter value after init (weakly taken).
REQ-006 SHALL have port clk  in  1  rising-edge clock; the only clock.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port pred_valid  in  1  predict request.
REQ-009 SHALL have port pred_pc  in  PC_WIDTH  branch PC to predict.
REQ-010 SHALL have port pred_ready  out  1  high when a predict request can be accepted.
REQ-011 SHALL have port resp_valid  out  1  response strobe, one cycle wide.
REQ-012 SHALL have port resp_taken  out  1  predicted direction (counter MSB).
REQ-013 SHALL have port resp_hist  out  HIST_BITS  GHR checkpoint used to form the index.
REQ-014 SHALL have port upd_valid  in  1  resolve/update request.
REQ-015 SHALL have port upd_pc  in  PC_WIDTH  PC of the resolved branch.
REQ-016 SHALL have port upd_hist  in  HIST_BITS  checkpoint returned with that branch's prediction.
REQ-017 SHALL have port upd_taken  in  1  actual direction.
REQ-018 SHALL have port upd_mispredict  in  1  prediction was wrong; restore history.
REQ-019 SHALL have port init_busy  out  1  high while the table-init sequencer runs.

Function
REQ-020 Index(pc,h) SHALL equal pc[PC_LSB +: INDEX_BITS] XOR h zero-extended to INDEX_BITS.
REQ-021 Table SHALL hold 2**INDEX_BITS 2-bit saturating counters; GHR SHALL be HIST_BITS wide.
REQ-022 FSM SHALL have states INIT and RUN; rst forces INIT with init pointer 0.
REQ-023 INIT: one entry per cycle written with INIT_STATE, pointer incrementing; at pointer 2**INDEX_BITS-1 the write completes and the next state is RUN.
REQ-024 INIT: init_busy=1, pred_ready=0; pred_valid and upd_valid SHALL be ignored.
REQ-025 RUN: init_busy=0, pred_ready=1.
REQ-026 A predict SHALL be accepted when pred_valid&&pred_ready.
REQ-027 On an accepted predict, the next cycle SHALL drive resp_valid=1, resp_taken=counter[Index(pred_pc,GHR)][1] and resp_hist=the pre-shift GHR.
REQ-028 resp_valid SHALL be 0 in every cycle not following an accepted predict; resp_taken and resp_hist hold their values.
REQ-029 On an accepted predict, GHR SHALL become {GHR[HIST_BITS-2:0], predicted bit} (speculative update); for HIST_BITS=1 it becomes the predicted bit.
REQ-030 On upd_valid in RUN: counter[Index(upd_pc,upd_hist)] SHALL increment if upd_taken and decrement otherwise, saturating at 3 and 0.
REQ-031 On upd_valid&&upd_mispredict: GHR SHALL become {upd_hist[HIST_BITS-2:0], upd_taken}, overriding any same-cycle speculative shift.
REQ-032 upd_valid without upd_mispredict SHALL leave GHR unchanged.
REQ-033 Predict and update to the same index in one cycle: predict SHALL read the pre-update counter (read-before-write); the update SHALL still be applied.
REQ-034 Updates on back-to-back cycles to the same index SHALL accumulate; no update is lost.

Reset
REQ-035 In the cycle after rst is sampled high: resp_valid=0, resp_taken=0, resp_hist=0, GHR=0, init_busy=1, pred_ready=0.
REQ-036 rst asserted during INIT or RUN SHALL restart INIT from pointer 0; a complete re-init SHALL follow.
REQ-037 rst SHALL take priority over every predict and update in the same cycle.

Verification (defaults; pc index = pc[13:2])
REQ-038 The bench SHALL check init timing: pulse rst for 1 cycle -> init_busy=1 for exactly 4096 cycles, then pred_ready=1.
REQ-039 The bench SHALL check predict after init: pred_pc=0x100 -> next cycle resp_valid=1, resp_taken=1, resp_hist=0x000; GHR becomes 0x001.
REQ-040 The bench SHALL check saturation: 3 updates upd_pc=0x100, upd_hist=0, upd_taken=0 -> counter[0x040]=00; a 4th stays 00; 3 taken -> 11; a 4th stays 11.
REQ-041 The bench SHALL check recovery: GHR=0x00F, then upd_valid, upd_mispredict=1, upd_hist=0x003, upd_taken=0, with a same-cycle predict -> GHR=0x006 next cycle.
REQ-042 The bench SHALL check same-index collision: counter=01 at an index, with a same-cycle predict there and taken update -> resp_taken=0, and a later read returns 10.
REQ-043 The bench SHALL check mid-init reset: rst at init pointer 100 -> init_busy stays high a further 4096 cycles; predict and update inputs during INIT have no effect.

Source files
------------

// File: rtl/gshare_spec_predictor.sv
// Gshare branch direction predictor with a speculative global history register,
// mispredict history recovery and a one-entry-per-cycle table init sequencer.
module gshare_spec_predictor #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INDEX_BITS = 12,
    parameter int unsigned HIST_BITS  = 12,
    parameter int unsigned PC_LSB     = 2,
    parameter logic [1:0]  INIT_STATE = 2'b10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    input  logic [PC_WIDTH-1:0]  pred_pc,
    output logic                 pred_ready,
    output logic                 resp_valid,
    output logic                 resp_taken,
    output logic [HIST_BITS-1:0] resp_hist,
    input  logic                 upd_valid,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic [HIST_BITS-1:0] upd_hist,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    output logic                 init_busy
);

    localparam int unsigned DEPTH = 2 ** INDEX_BITS;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                state_q;
    logic [INDEX_BITS-1:0] ptr_q;
    logic [HIST_BITS-1:0]  ghr_q;
    logic [HIST_BITS-1:0]  ghr_d;
    logic [1:0]            cnt_q [DEPTH];
    logic                  resp_valid_q;
    logic                  resp_taken_q;
    logic [HIST_BITS-1:0]  resp_hist_q;

    logic                  running;
    logic                  pred_fire;
    logic                  upd_fire;
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [1:0]            pred_ctr;
    logic [1:0]            upd_ctr;
    logic [1:0]            upd_ctr_d;
    logic                  unused_pc_bits;

    assign running   = (state_q == S_RUN);
    assign pred_fire = pred_valid && running;
    assign upd_fire  = upd_valid && running;

    assign pred_idx  = pred_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(ghr_q);
    assign upd_idx   = upd_pc[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(upd_hist);
    assign pred_ctr  = cnt_q[pred_idx];
    assign upd_ctr   = cnt_q[upd_idx];

    assign unused_pc_bits = ^{pred_pc, upd_pc};

    always_comb begin
        upd_ctr_d = upd_ctr;
        if (upd_taken && (upd_ctr != 2'b11)) begin
            upd_ctr_d = upd_ctr + 2'b01;
        end else if (!upd_taken && (upd_ctr != 2'b00)) begin
            upd_ctr_d = upd_ctr - 2'b01;
        end
    end

    // Truncating {hist, bit} to HIST_BITS drops the oldest bit; also valid for HIST_BITS=1.
    always_comb begin
        ghr_d = ghr_q;
        if (pred_fire) begin
            ghr_d = HIST_BITS'({ghr_q, pred_ctr[1]});
        end
        if (upd_fire && upd_mispredict) begin
            ghr_d = HIST_BITS'({upd_hist, upd_taken});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            ptr_q        <= '0;
            ghr_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_taken_q <= 1'b0;
            resp_hist_q  <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    resp_valid_q <= 1'b0;
                    ptr_q        <= ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    resp_valid_q <= pred_fire;
                    if (pred_fire) begin
                        resp_taken_q <= pred_ctr[1];
                        resp_hist_q  <= ghr_q;
                    end
                    ghr_q <= ghr_d;
                end
            endcase
        end
    end

    // Predict reads the array combinationally before this write lands (read-before-write).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) begin
                cnt_q[ptr_q] <= INIT_STATE;
            end else if (upd_fire) begin
                cnt_q[upd_idx] <= upd_ctr_d;
            end
        end
    end

    assign pred_ready = running;
    assign init_busy  = (state_q == S_INIT);
    assign resp_valid = resp_valid_q;
    assign resp_taken = resp_taken_q;
    assign resp_hist  = resp_hist_q;

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Scoreboard bench for gshare_spec_predictor at default parameters, with an
// array-based reference model of the counter table and global history.
module tb_gshare_spec_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_ready;
    logic        resp_valid;
    logic        resp_taken;
    logic [11:0] resp_hist;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [11:0] upd_hist = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic        init_busy;

    always #5 clk = ~clk;

    gshare_spec_predictor #(
        .PC_WIDTH(32),
        .INDEX_BITS(12),
        .HIST_BITS(12),
        .PC_LSB(2),
        .INIT_STATE(2'b10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pred_valid(pred_valid),
        .pred_pc(pred_pc),
        .pred_ready(pred_ready),
        .resp_valid(resp_valid),
        .resp_taken(resp_taken),
        .resp_hist(resp_hist),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_hist(upd_hist),
        .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict),
        .init_busy(init_busy)
    );

    int          checks = 0;
    int          errors = 0;
    bit [12:0]   exp_q[$];
    int          cnt_m[4096];
    bit [11:0]   ghr_m;
    bit          run_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per response strobe.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected 0 at %0t", $time);
            end else begin
                bit [12:0] e;
                e = exp_q.pop_front();
                chk("resp_taken", {31'b0, resp_taken}, {31'b0, e[12]});
                chk("resp_hist", {20'b0, resp_hist}, {20'b0, e[11:0]});
            end
        end else if (exp_q.size() != 0) begin
            checks++;
            errors++;
            void'(exp_q.pop_front());
            $display("FAIL missing_resp: got resp_valid=%b expected 1 at %0t", resp_valid, $time);
        end
    end

    // One clock of stimulus; the reference model advances only while it believes the DUT runs.
    task automatic cyc(input bit pv, input bit [31:0] ppc, input bit uv, input bit [31:0] upc,
                       input bit [11:0] uh, input bit ut, input bit um);
        bit [11:0] pi, ui, ng;
        bit [12:0] e;
        bit        have;
        have = 1'b0;
        pred_valid = pv; pred_pc = ppc;
        upd_valid = uv; upd_pc = upc; upd_hist = uh; upd_taken = ut; upd_mispredict = um;
        if (run_m) begin
            ng = ghr_m;
            if (pv) begin
                pi = ppc[13:2] ^ ghr_m;
                e = {cnt_m[pi] >= 2, ghr_m};
                have = 1'b1;
                ng = {ghr_m[10:0], cnt_m[pi] >= 2};
            end
            if (uv) begin
                ui = upc[13:2] ^ uh;
                if (ut) cnt_m[ui] = (cnt_m[ui] == 3) ? 3 : cnt_m[ui] + 1;
                else    cnt_m[ui] = (cnt_m[ui] == 0) ? 0 : cnt_m[ui] - 1;
                if (um) ng = {uh[10:0], ut};
            end
            ghr_m = ng;
        end
        @(posedge clk);
        if (have) exp_q.push_back(e);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd_cyc();
        bit [31:0] p1, p2;
        p1 = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
        p2 = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
        cyc(1'($urandom), p1, 1'($urandom), p2, 12'($urandom_range(0, 15)),
            1'($urandom), $urandom_range(0, 3) == 0);
    endtask

    // Predict whose index lands on idx given the model's current history.
    task automatic rd(input bit [11:0] idx);
        bit [31:0] p;
        bit [11:0] s;
        s = idx ^ ghr_m;
        p = ($urandom & 32'hFFFF_C003) | {18'b0, s, 2'b00};
        cyc(1, p, 0, 0, 0, 0, 0);
    endtask

    task automatic do_rst();
        run_m = 1'b0;
        rst = 1'b1;
        pred_valid = 1'b1; pred_pc = $urandom;
        upd_valid = 1'b1; upd_pc = $urandom; upd_hist = 12'($urandom);
        upd_taken = 1'b1; upd_mispredict = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_resp_taken", {31'b0, resp_taken}, 0);
        chk("rst_resp_hist", {20'b0, resp_hist}, 0);
        chk("rst_init_busy", {31'b0, init_busy}, 1);
        chk("rst_pred_ready", {31'b0, pred_ready}, 0);
    endtask

    task automatic wait_init(input string nm, input int pre);
        int n;
        n = pre;
        while (init_busy === 1'b1 && n < 5000) begin
            rnd_cyc();
            n++;
        end
        chk(nm, n, 4096);
        chk("pred_ready_after_init", {31'b0, pred_ready}, 1);
        chk("init_busy_after_init", {31'b0, init_busy}, 0);
        for (int i = 0; i < 4096; i++) cnt_m[i] = 2;
        ghr_m = '0;
        run_m = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        do_rst();
        wait_init("init_cycles", 0);

        cyc(1, 32'h100, 0, 0, 0, 0, 0);
        idle();

        repeat (4) cyc(0, 0, 1, 32'h100, 12'h000, 0, 0);
        rd(12'h040);
        cyc(0, 0, 1, 32'h100, 12'h000, 1, 0);
        rd(12'h040);
        repeat (3) cyc(0, 0, 1, 32'h100, 12'h000, 1, 0);
        rd(12'h040);
        cyc(0, 0, 1, 32'h100, 12'h000, 0, 0);
        rd(12'h040);
        cyc(0, 0, 1, 32'h100, 12'h000, 0, 0);
        rd(12'h040);

        cyc(0, 0, 1, 32'h0000_0800, 12'h007, 1, 1);
        cyc(1, 32'h0000_1234, 1, 32'h0000_0400, 12'h003, 0, 1);
        rd(12'h123);
        idle();

        cyc(0, 0, 1, 32'h0000_0A94, 12'h000, 0, 0);
        cyc(1, {18'b0, 12'h2A5 ^ ghr_m, 2'b00}, 1, 32'h0000_0A94, 12'h000, 1, 0);
        rd(12'h2A5);
        idle();

        repeat (400) rnd_cyc();
        idle();

        do_rst();
        repeat (100) rnd_cyc();
        do_rst();
        wait_init("init_cycles_after_midreset", 0);
        rd(12'h040);
        rd(12'h2A5);
        repeat (8) rd(12'($urandom_range(0, 63)));
        repeat (50) rnd_cyc();
        idle();
        idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
